uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter between `N_REQ` byte sources. Each requester offers a byte plus its own parity settings over a valid/ready handshake. The block grants one requester at a time, launches the frame on the transmitter, waits for it to finish, and signals completion or a start timeout. It sits between the application sources (button/data capture, sensor packers) and the UART TX core, in the `clk` domain.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 64: max `clk` cycles in WAIT_BUSY before a start timeout is declared (≥1).
- `GAP_CYCLES`, 2: idle `clk` cycles enforced after each frame (0 allowed).

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  requester i offers a byte.
- `req_data`  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
- `req_parity_en`  in  N_REQ  parity enable for requester i's frame.
- `req_parity_kind`  in  N_REQ  1 = odd, 0 = even, per requester.
- `req_ready`  out  N_REQ  one-hot accept strobe; combinational.
- `done`  out  N_REQ  one-cycle pulse: requester i's frame completed.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  8  frame byte; held from accept until the next accept.
- `tx_parity_en`, `tx_parity_kind`  out  1 each  held the same way as `tx_data`.
- `tx_busy`  in  1  transmitter busy (frame in progress).
- `err_timeout`  out  1  one-cycle pulse on a start timeout.
- `err_flag`  out  1  sticky error; cleared by `err_clr` or `rst`.
- `err_clr`  in  1  clears `err_flag`.
- `grant_idx`  out  clog2(N_REQ)  index of the last accepted requester.

## Operation
- States:
  - IDLE: arbitrates.
  - LAUNCH: drives `tx_start`.
  - WAIT_BUSY: waits for `tx_busy` to rise, counting cycles.
  - SENDING: waits for `tx_busy` to fall.
  - GAP: counts out the inter-frame gap.
- IDLE:
  - When `tx_busy`=0 and any `req_valid` is high, `req_ready[w]`=1 for the round-robin winner w only.
  - At that edge: capture `req_data[w]`, `req_parity_en[w]` and `req_parity_kind[w]` into `tx_*`; set `grant_idx`=w; go to LAUNCH.
  - If `tx_busy`=1 in IDLE, no grant is made.
- Round-robin: search starts at (`grant_idx`+1) mod N_REQ and wraps. After reset the pointer makes requester 0 highest priority.
- LAUNCH: `tx_start`=1 for exactly this cycle, then WAIT_BUSY with the counter cleared.
- WAIT_BUSY:
  - `tx_busy`=1 → SENDING.
  - Otherwise the counter increments. When the counter reaches TIMEOUT, pulse `err_timeout`, set `err_flag`, go to GAP.
  - No `done` is produced on timeout.
- SENDING: `tx_busy`=0 → pulse `done[grant_idx]`, go to GAP.
- GAP: stay GAP_CYCLES cycles, then IDLE. GAP_CYCLES=0 → IDLE on the next cycle.
- `req_ready` is 0 in every state except IDLE. A requester that drops `req_valid` before being granted loses nothing; no data is latched.
- `err_clr` and a same-cycle timeout: set wins, so `err_flag`=1.
- Reset mid-frame: state returns to IDLE and all outputs go to their reset values. An in-flight frame gets no `done`.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=0, `tx_parity_en`=0, `tx_parity_kind`=0.
  - `done`=0, `err_timeout`=0, `err_flag`=0, `grant_idx`=N_REQ-1.
  - `req_ready`=0 while `rst`=1.
- Accept at edge t → `tx_start` high during cycle t+1 → first `tx_busy` sample in WAIT_BUSY at cycle t+2.
- `done` is high in the cycle after `tx_busy` is sampled low in SENDING.
- The next accept is possible GAP_CYCLES+1 cycles after `done`.
- All outputs except `req_ready` are registered.

## Test plan
- Single request: N_REQ=4, req 2 valid with 0xA5 and odd parity; TX model raises busy 3 cycles after start and holds it 20 cycles.
  - `req_ready[2]` pulses once; `tx_start` is a 1-cycle pulse with `tx_data`=0xA5 and `tx_parity_kind`=1.
  - `done[2]` pulses once; the next accept is no earlier than 3 cycles after `done`.
- All four requesters valid continuously: grant order 0,1,2,3,0,…, each frame's `tx_data` matches its requester.
- Timeout: TX model never raises busy, TIMEOUT=64.
  - `err_timeout` pulses exactly 64 cycles after WAIT_BUSY entry; `err_flag` stays 1; no `done`.
  - `err_clr` returns `err_flag` to 0.
- `tx_busy` held high while requests are pending: no `req_ready` until busy drops.
- Reset asserted during SENDING:
  - Next cycle: all outputs at reset values, no `done`.
  - After release, req 0 has priority and is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources.
// Grants one requester, launches its frame, waits for completion or a start timeout.
module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    input  logic [N_REQ-1:0]           req_parity_en,
    input  logic [N_REQ-1:0]           req_parity_kind,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           done,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       tx_parity_en,
    output logic                       tx_parity_kind,
    input  logic                       tx_busy,
    output logic                       err_timeout,
    output logic                       err_flag,
    input  logic                       err_clr,
    output logic [$clog2(N_REQ)-1:0]   grant_idx
);

    localparam int IW   = $clog2(N_REQ);
    localparam int CMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        SENDING,
        GAP
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_parity_en_q, tx_parity_en_d;
    logic             tx_parity_kind_q, tx_parity_kind_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_flag_q, err_flag_d;
    logic [IW-1:0]    grant_q, grant_d;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        int   cand;
        int   win;
        logic win_found;

        state_d          = state_q;
        cnt_d            = cnt_q;
        tx_start_d       = 1'b0;
        tx_data_d        = tx_data_q;
        tx_parity_en_d   = tx_parity_en_q;
        tx_parity_kind_d = tx_parity_kind_q;
        done_d           = '0;
        err_timeout_d    = 1'b0;
        err_flag_d       = err_clr ? 1'b0 : err_flag_q;
        grant_d          = grant_q;
        req_ready        = '0;
        cand             = 0;
        win              = 0;
        win_found        = 1'b0;

        // Search starts one past the last grant and wraps around.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(grant_q) + k) % N_REQ;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (!tx_busy && win_found) begin
                    req_ready[win]   = 1'b1;
                    tx_data_d        = req_data[8*win +: 8];
                    tx_parity_en_d   = req_parity_en[win];
                    tx_parity_kind_d = req_parity_kind[win];
                    grant_d          = IW'(win);
                    tx_start_d       = 1'b1;
                    state_d          = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = SENDING;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(TIMEOUT)) begin
                        err_timeout_d = 1'b1;
                        err_flag_d    = 1'b1;  // a same-cycle err_clr loses
                        cnt_d         = '0;
                        state_d       = GAP;
                    end
                end
            end
            SENDING: begin
                if (!tx_busy) begin
                    done_d[grant_q] = 1'b1;
                    cnt_d           = '0;
                    state_d         = GAP;
                end
            end
            GAP: begin
                // GAP always lasts at least one cycle, even with GAP_CYCLES = 0.
                if (int'(cnt_q) + 1 >= GAP_CYCLES) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            req_ready = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            tx_start_q       <= 1'b0;
            tx_data_q        <= 8'h00;
            tx_parity_en_q   <= 1'b0;
            tx_parity_kind_q <= 1'b0;
            done_q           <= '0;
            err_timeout_q    <= 1'b0;
            err_flag_q       <= 1'b0;
            grant_q          <= IW'(N_REQ - 1);
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            tx_start_q       <= tx_start_d;
            tx_data_q        <= tx_data_d;
            tx_parity_en_q   <= tx_parity_en_d;
            tx_parity_kind_q <= tx_parity_kind_d;
            done_q           <= done_d;
            err_timeout_q    <= err_timeout_d;
            err_flag_q       <= err_flag_d;
            grant_q          <= grant_d;
        end
    end

    assign tx_start       = tx_start_q;
    assign tx_data        = tx_data_q;
    assign tx_parity_en   = tx_parity_en_q;
    assign tx_parity_kind = tx_parity_kind_q;
    assign done           = done_q;
    assign err_timeout    = err_timeout_q;
    assign err_flag       = err_flag_q;
    assign grant_idx      = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=64, GAP_CYCLES=2).
// The bench itself plays the UART TX core by driving tx_busy.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_parity_en;
    logic [N-1:0]   req_parity_kind;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   done;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_parity_en;
    logic           tx_parity_kind;
    logic           tx_busy;
    logic           err_timeout;
    logic           err_flag;
    logic           err_clr;
    logic [1:0]     grant_idx;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(64), .GAP_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_parity_en  (req_parity_en),
        .req_parity_kind(req_parity_kind),
        .req_ready      (req_ready),
        .done           (done),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .tx_parity_en   (tx_parity_en),
        .tx_parity_kind (tx_parity_kind),
        .tx_busy        (tx_busy),
        .err_timeout    (err_timeout),
        .err_flag       (err_flag),
        .err_clr        (err_clr),
        .grant_idx      (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // One complete frame: busy rises two cycles after start, lasts three cycles.
    task automatic run_frame(input logic [3:0] exp_oh, input logic [7:0] exp_data,
                             input logic exp_kind, input logic [1:0] exp_idx);
        int w;
        w = 0;
        while (req_ready == '0 && w < 20) begin
            tick();
            w++;
        end
        check("rr_ready", req_ready, exp_oh);
        tick();
        check("rr_start", tx_start, 1);
        check("rr_data", tx_data, exp_data);
        check("rr_kind", tx_parity_kind, exp_kind);
        check("rr_grant", grant_idx, exp_idx);
        tick();
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        tick();
        tx_busy = 1'b0;
        w = 0;
        while (done == '0 && w < 10) begin
            tick();
            w++;
        end
        check("rr_done", done, exp_oh);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt;
        int done_at;
        logic [3:0] done_val;
        int ready_at;
        logic [3:0] ready_val;
        int to_cnt;
        int to_at;
        int w;

        rst             = 1'b1;
        req_valid       = '0;
        req_data        = {8'h44, 8'hA5, 8'h22, 8'h11};
        req_parity_en   = 4'b0100;
        req_parity_kind = 4'b0100;
        tx_busy         = 1'b0;
        err_clr         = 1'b0;
        tick();
        tick();

        // Reset values; req_ready stays low while rst is high.
        req_valid = 4'hF;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_parity_en", tx_parity_en, 0);
        check("rst_parity_kind", tx_parity_kind, 0);
        check("rst_done", done, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_grant", grant_idx, 3);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Single request from requester 2, odd parity.
        req_valid = 4'b0100;
        #1;
        check("single_ready", req_ready, 4'b0100);
        tick();                                   // accept edge E0
        check("single_start", tx_start, 1);
        check("single_data", tx_data, 8'hA5);
        check("single_kind", tx_parity_kind, 1);
        check("single_en", tx_parity_en, 1);
        check("single_grant", grant_idx, 2);
        check("launch_no_ready", req_ready, 0);
        req_valid = '0;
        tick();                                   // E1
        check("start_one_cycle", tx_start, 0);
        check("data_held", tx_data, 8'hA5);
        tick();                                   // E2
        tx_busy   = 1'b1;
        done_cnt  = 0;
        done_at   = 0;
        done_val  = '0;
        ready_at  = 0;
        ready_val = '0;
        for (int c = 3; c <= 26; c++) begin
            tick();
            if (c == 10) req_valid = 4'b0010;
            if (c == 22) tx_busy = 1'b0;
            if (done != '0) begin
                done_cnt++;
                done_at  = c;
                done_val = done;
            end
            if (req_ready != '0 && ready_at == 0) begin
                ready_at  = c;
                ready_val = req_ready;
            end
        end
        check("single_done_count", done_cnt, 1);
        check("single_done_cycle", done_at, 23);
        check("single_done_onehot", done_val, 4'b0100);
        check("next_ready_cycle", ready_at, 25);
        check("next_ready_who", ready_val, 4'b0010);
        check("next_data", tx_data, 8'h22);
        check("next_grant", grant_idx, 1);

        // All four requesters valid: grant order 0,1,2,3,0.
        req_data        = {8'h44, 8'h33, 8'h22, 8'h11};
        req_parity_en   = 4'hF;
        req_parity_kind = 4'b1010;
        req_valid       = 4'hF;
        tx_busy         = 1'b0;
        do_reset();
        run_frame(4'b0001, 8'h11, 1'b0, 2'd0);
        run_frame(4'b0010, 8'h22, 1'b1, 2'd1);
        run_frame(4'b0100, 8'h33, 1'b0, 2'd2);
        run_frame(4'b1000, 8'h44, 1'b1, 2'd3);
        run_frame(4'b0001, 8'h11, 1'b0, 2'd0);

        // Transmitter busy while requests pend: no grant until it drops.
        tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("busy_blocks_ready", req_ready, 0);
        end
        tx_busy = 1'b0;
        #1;
        check("busy_drop_ready", req_ready, 4'b0010);
        tick();                                   // accept requester 1
        req_valid = '0;

        // Busy never rises: timeout 64 cycles after WAIT_BUSY entry.
        to_cnt   = 0;
        to_at    = 0;
        done_cnt = 0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (err_timeout) begin
                to_cnt++;
                to_at = k;
            end
            if (done != '0) done_cnt++;
        end
        check("timeout_count", to_cnt, 1);
        check("timeout_cycle", to_at, 65);
        check("timeout_no_done", done_cnt, 0);
        check("timeout_flag_sticky", err_flag, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr_clears", err_flag, 0);

        // Timeout coinciding with err_clr: the set wins for that cycle.
        req_valid = 4'b1000;
        #1;
        check("to2_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        err_clr   = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            tick();
            if (k == 65) begin
                check("set_wins_pulse", err_timeout, 1);
                check("set_wins_flag", err_flag, 1);
            end
            if (k == 66) check("clr_after_set", err_flag, 0);
        end
        err_clr = 1'b0;

        // Reset while SENDING: outputs return to reset values, no done.
        req_valid = 4'b0001;
        w = 0;
        while (req_ready == '0 && w < 20) begin
            tick();
            w++;
        end
        check("pre_rst_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        check("pre_rst_grant", grant_idx, 0);
        check("pre_rst_data", tx_data, 8'h11);
        req_valid = 4'b0011;
        rst = 1'b1;
        tick();
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_parity_en", tx_parity_en, 0);
        check("mid_rst_parity_kind", tx_parity_kind, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err_timeout", err_timeout, 0);
        check("mid_rst_err_flag", err_flag, 0);
        check("mid_rst_grant", grant_idx, 3);
        check("mid_rst_ready", req_ready, 0);
        tx_busy = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_priority", req_ready, 4'b0001);
        check("post_rst_no_done", done, 0);
        tick();
        check("post_rst_grant", grant_idx, 0);
        check("post_rst_data", tx_data, 8'h11);
        check("post_rst_no_done2", done, 0);
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
